// File: rtl/seg7_scan_to_bcd.sv
// Samples a scanned common-cathode 7-segment bus, decodes each glyph to BCD and emits full frames over valid/ready.
// Define SEG7_ALT_GLYPH_EN to also accept the alternate 6 / 7 / 9 glyph shapes.
module seg7_scan_to_bcd #(
    parameter int NUM_DIGITS     = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   dig_sel_i,
    input  logic                    scan_vld_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic [NUM_DIGITS-1:0]   dig_err_o,
    output logic                    frm_vld_o,
    input  logic                    frm_rdy_i,
    output logic                    sel_err_o,
    output logic                    ovr_o,
    input  logic                    ovr_clr_i
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                    state_reg, state_next;
    logic [IDX_W-1:0]          idx_reg, idx_next;

    logic [6:0]                seg_eff;
    logic [3:0]                glyph_val;
    logic                      glyph_err;
    logic                      sel_onehot;
    logic [IDX_W-1:0]          sel_idx;

    logic [NUM_DIGITS-2:0]     shadow_we;
    logic                      shadow_clr;
    logic                      frame_done;
    logic                      sel_err_next;

    logic [4*NUM_DIGITS-5:0]   shadow_bcd;
    logic [NUM_DIGITS-2:0]     shadow_err;
    logic [4*NUM_DIGITS-1:0]   frame_bcd;
    logic [NUM_DIGITS-1:0]     frame_err;

    logic [4*NUM_DIGITS-1:0]   bcd_reg;
    logic [NUM_DIGITS-1:0]     dig_err_reg;
    logic                      frm_vld_reg;
    logic                      sel_err_reg;
    logic                      ovr_reg;

    assign seg_eff = SEG_ACTIVE_LOW ? ~seg_i : seg_i;

    always_comb begin
        glyph_val = 4'hF;
        glyph_err = 1'b0;
        case (seg_eff)
            7'b1111110: glyph_val = 4'h0;
            7'b0110000: glyph_val = 4'h1;
            7'b1101101: glyph_val = 4'h2;
            7'b1111001: glyph_val = 4'h3;
            7'b0110011: glyph_val = 4'h4;
            7'b1011011: glyph_val = 4'h5;
            7'b1011111: glyph_val = 4'h6;
            7'b1110000: glyph_val = 4'h7;
            7'b1111111: glyph_val = 4'h8;
            7'b1111011: glyph_val = 4'h9;
            7'b0000000: glyph_val = 4'hA;
`ifdef SEG7_ALT_GLYPH_EN
            7'b0011111: glyph_val = 4'h6;
            7'b1110010: glyph_val = 4'h7;
            7'b1110011: glyph_val = 4'h9;
`endif
            default: begin
                glyph_val = 4'hF;
                glyph_err = 1'b1;
            end
        endcase
    end

    assign sel_onehot = (dig_sel_i != '0) &&
                        ((dig_sel_i & (dig_sel_i - NUM_DIGITS'(1))) == '0);

    // Priority encoder is only meaningful when sel_onehot is true.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_sel_i[i]) sel_idx = i[IDX_W-1:0];
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        shadow_we    = '0;
        shadow_clr   = 1'b0;
        frame_done   = 1'b0;
        sel_err_next = 1'b0;
        if (scan_vld_i) begin
            if (!sel_onehot) begin
                state_next   = IDLE;
                idx_next     = '0;
                shadow_clr   = 1'b1;
                sel_err_next = 1'b1;
            end else if (sel_idx == '0) begin
                shadow_we  = dig_sel_i[NUM_DIGITS-2:0];
                idx_next   = IDX_W'(1);
                state_next = COLLECT;
            end else if (state_reg == COLLECT) begin
                if (sel_idx == idx_reg) begin
                    shadow_we = dig_sel_i[NUM_DIGITS-2:0];
                    if (sel_idx == IDX_W'(NUM_DIGITS - 1)) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end else begin
                    state_next   = IDLE;
                    idx_next     = '0;
                    shadow_clr   = 1'b1;
                    sel_err_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // The last digit is never held in the shadow: it goes straight from the decoder into the frame.
    for (genvar gi = 0; gi < NUM_DIGITS - 1; gi++) begin : g_shadow
        logic [3:0] nib_reg;
        logic       err_reg;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                nib_reg <= '0;
                err_reg <= 1'b0;
            end else if (shadow_clr) begin
                nib_reg <= '0;
                err_reg <= 1'b0;
            end else if (shadow_we[gi]) begin
                nib_reg <= glyph_val;
                err_reg <= glyph_err;
            end
        end
        assign shadow_bcd[4*gi +: 4] = nib_reg;
        assign shadow_err[gi]        = err_reg;
    end

    assign frame_bcd = {glyph_val, shadow_bcd};
    assign frame_err = {glyph_err, shadow_err};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bcd_reg     <= '0;
            dig_err_reg <= '0;
            frm_vld_reg <= 1'b0;
            sel_err_reg <= 1'b0;
            ovr_reg     <= 1'b0;
        end else begin
            sel_err_reg <= sel_err_next;
            if (frame_done) begin
                bcd_reg     <= frame_bcd;
                dig_err_reg <= frame_err;
                frm_vld_reg <= 1'b1;
            end else if (frm_vld_reg && frm_rdy_i) begin
                frm_vld_reg <= 1'b0;
            end
            // A new overrun takes priority over a clear in the same cycle.
            if (frame_done && frm_vld_reg && !frm_rdy_i) begin
                ovr_reg <= 1'b1;
            end else if (ovr_clr_i) begin
                ovr_reg <= 1'b0;
            end
        end
    end

    assign bcd_o     = bcd_reg;
    assign dig_err_o = dig_err_reg;
    assign frm_vld_o = frm_vld_reg;
    assign sel_err_o = sel_err_reg;
    assign ovr_o     = ovr_reg;

endmodule

// File: tb/tb_seg7_scan_to_bcd.sv
// Bench for seg7_scan_to_bcd: an active-high and an active-low instance see the same glyphs, checked every cycle
// against a frame-level reference model, plus a vector table and hand-written protocol sequences.
module tb_seg7_scan_to_bcd;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [6:0]  seg_n;
    logic [3:0]  sel;
    logic        vld, rdy, clr;

    logic [15:0] bcd_h, bcd_l;
    logic [3:0]  err_h, err_l;
    logic        fv_h, fv_l, se_h, se_l, ov_h, ov_l;

    assign seg_n = ~seg;

    seg7_scan_to_bcd #(.NUM_DIGITS(N), .SEG_ACTIVE_LOW(1'b0)) u_high (
        .clk_i(clk), .rst_ni(rst_n), .seg_i(seg), .dig_sel_i(sel), .scan_vld_i(vld),
        .bcd_o(bcd_h), .dig_err_o(err_h), .frm_vld_o(fv_h), .frm_rdy_i(rdy),
        .sel_err_o(se_h), .ovr_o(ov_h), .ovr_clr_i(clr)
    );

    seg7_scan_to_bcd #(.NUM_DIGITS(N), .SEG_ACTIVE_LOW(1'b1)) u_low (
        .clk_i(clk), .rst_ni(rst_n), .seg_i(seg_n), .dig_sel_i(sel), .scan_vld_i(vld),
        .bcd_o(bcd_l), .dig_err_o(err_l), .frm_vld_o(fv_l), .frm_rdy_i(rdy),
        .sel_err_o(se_l), .ovr_o(ov_l), .ovr_clr_i(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    logic [6:0] glyph_tab [10];

    // Reference model state
    logic        m_act;
    int          m_next;
    logic [3:0]  m_val [N];
    logic [N-1:0] m_e;
    logic [15:0] m_bcd;
    logic [3:0]  m_derr;
    logic        m_vld, m_sel, m_ovr;

    typedef struct {
        logic [27:0] glyphs;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_err;
    } vec_t;
    vec_t tab [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] model_decode(input logic [6:0] g);
        logic [4:0] r;
        r = 5'h1F;
        if (g == 7'b0000000) r = 5'h0A;
        for (int i = 0; i < 10; i++) begin
            if (glyph_tab[i] == g) r = {1'b0, 4'(i)};
        end
`ifdef SEG7_ALT_GLYPH_EN
        if (g == 7'b0011111) r = 5'h06;
        if (g == 7'b1110010) r = 5'h07;
        if (g == 7'b1110011) r = 5'h09;
`endif
        return r;
    endfunction

    function automatic logic [27:0] glyphs_of(input logic [15:0] vals);
        logic [27:0] g;
        for (int k = 0; k < N; k++) g[7*k +: 7] = glyph_tab[vals[4*k +: 4]];
        return g;
    endfunction

    task automatic model_reset();
        m_act = 1'b0; m_next = 0; m_e = '0; m_bcd = '0; m_derr = '0;
        m_vld = 1'b0; m_sel = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < N; i++) m_val[i] = '0;
    endtask

    task automatic model_update();
        logic [4:0] d;
        int         k;
        logic       done, err_ev, hs;
        done = 1'b0; err_ev = 1'b0; hs = m_vld && rdy;
        if (vld) begin
            if ($countones(sel) != 1) begin
                err_ev = 1'b1; m_act = 1'b0;
            end else begin
                k = 0;
                for (int i = 0; i < N; i++) if (sel[i]) k = i;
                d = model_decode(seg);
                if (k == 0) begin
                    m_val[0] = d[3:0]; m_e[0] = d[4]; m_next = 1; m_act = 1'b1;
                end else if (m_act) begin
                    if (k == m_next) begin
                        m_val[k] = d[3:0]; m_e[k] = d[4]; m_next++;
                        if (k == N - 1) begin done = 1'b1; m_act = 1'b0; end
                    end else begin
                        err_ev = 1'b1; m_act = 1'b0;
                    end
                end
            end
        end
        m_sel = err_ev;
        if (done) begin
            if (m_vld && !rdy) m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
            for (int i = 0; i < N; i++) m_bcd[4*i +: 4] = m_val[i];
            m_derr = m_e;
            m_vld  = 1'b1;
        end else begin
            if (hs) m_vld = 1'b0;
            if (clr) m_ovr = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("bcd", 32'(bcd_h), 32'(m_bcd));
        chk("dig_err", 32'(err_h), 32'(m_derr));
        chk("frm_vld", 32'(fv_h), 32'(m_vld));
        chk("sel_err", 32'(se_h), 32'(m_sel));
        chk("ovr", 32'(ov_h), 32'(m_ovr));
        chk("lo_bcd", 32'(bcd_l), 32'(m_bcd));
        chk("lo_dig_err", 32'(err_l), 32'(m_derr));
        chk("lo_frm_vld", 32'(fv_l), 32'(m_vld));
        chk("lo_sel_err", 32'(se_l), 32'(m_sel));
        chk("lo_ovr", 32'(ov_l), 32'(m_ovr));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bcd"}, 32'(bcd_h), 32'h0);
        chk({tag, "_err"}, 32'(err_h), 32'h0);
        chk({tag, "_vld"}, 32'(fv_h), 32'h0);
        chk({tag, "_selerr"}, 32'(se_h), 32'h0);
        chk({tag, "_ovr"}, 32'(ov_h), 32'h0);
        chk({tag, "_lo_bcd"}, 32'(bcd_l), 32'h0);
        chk({tag, "_lo_vld"}, 32'(fv_l), 32'h0);
    endtask

    // One clock: drive inputs, advance model on the edge, compare just after it.
    task automatic step(input logic [6:0] g, input logic [3:0] s, input logic v,
                        input logic r, input logic c);
        seg = g; sel = s; vld = v; rdy = r; clr = c;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic idle(input logic r, input logic c);
        step(7'h00, 4'h0, 1'b0, r, c);
    endtask

    task automatic scan(input logic [27:0] g, input logic r_other, input logic r_last);
        for (int k = 0; k < N; k++) begin
            step(g[7*k +: 7], 4'(1 << k), 1'b1, (k == N - 1) ? r_last : r_other, 1'b0);
            if (k == 1) step(7'($urandom), 4'($urandom), 1'b0, r_other, 1'b0);
        end
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        vld = 1'b0; rdy = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_all();
    endtask

    initial begin
        logic [27:0] frame_a, frame_b;
        int          pos;
        logic [3:0]  s;
        logic [6:0]  g;
        logic        v;
        int          r;

        glyph_tab[0] = 7'b1111110; glyph_tab[1] = 7'b0110000; glyph_tab[2] = 7'b1101101;
        glyph_tab[3] = 7'b1111001; glyph_tab[4] = 7'b0110011; glyph_tab[5] = 7'b1011011;
        glyph_tab[6] = 7'b1011111; glyph_tab[7] = 7'b1110000; glyph_tab[8] = 7'b1111111;
        glyph_tab[9] = 7'b1111011;

        tab[0] = '{{7'b0110000, 7'b1101101, 7'b1111110, 7'b1111001}, 16'h1203, 4'b0000};
        tab[1] = '{{7'b0110000, 7'b1000001, 7'b0000000, 7'b1111110}, 16'h1FA0, 4'b0100};
        tab[2] = '{{7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, 16'h8888, 4'b0000};
        tab[3] = '{{7'b1111011, 7'b1110000, 7'b1011011, 7'b0110011}, 16'h9754, 4'b0000};
`ifdef SEG7_ALT_GLYPH_EN
        tab[4] = '{{7'b1011111, 7'b1110011, 7'b1110010, 7'b0011111}, 16'h6976, 4'b0000};
`else
        tab[4] = '{{7'b1011111, 7'b1110011, 7'b1110010, 7'b0011111}, 16'h6FFF, 4'b0111};
`endif
        tab[5] = '{{7'b0000001, 7'b0000000, 7'b1011111, 7'b1111111}, 16'hFA68, 4'b1000};

        rst_n = 1'b0; seg = '0; sel = '0; vld = 1'b0; rdy = 1'b0; clr = 1'b0;
        model_reset();
        #1;
        chk_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector table: frame shows up right after the digit-3 sample, then drops after the handshake.
        for (int i = 0; i < 6; i++) begin
            scan(tab[i].glyphs, 1'b1, 1'b1);
            chk("tab_vld", 32'(fv_h), 32'h1);
            chk("tab_bcd", 32'(bcd_h), 32'(tab[i].exp_bcd));
            chk("tab_err", 32'(err_h), 32'(tab[i].exp_err));
            chk("tab_lo_bcd", 32'(bcd_l), 32'(tab[i].exp_bcd));
            idle(1'b1, 1'b0);
            chk("tab_vld_drop", 32'(fv_h), 32'h0);
        end

        // Out-of-order scan 0,1,3
        step(glyph_tab[1], 4'b0001, 1'b1, 1'b1, 1'b0);
        step(glyph_tab[2], 4'b0010, 1'b1, 1'b1, 1'b0);
        step(glyph_tab[3], 4'b1000, 1'b1, 1'b1, 1'b0);
        chk("order_selerr", 32'(se_h), 32'h1);
        chk("order_noframe", 32'(fv_h), 32'h0);
        idle(1'b1, 1'b0);
        chk("order_selerr_pulse", 32'(se_h), 32'h0);
        scan(tab[0].glyphs, 1'b0, 1'b0);
        chk("recover_vld", 32'(fv_h), 32'h1);
        chk("recover_bcd", 32'(bcd_h), 32'h1203);
        idle(1'b1, 1'b0);

        // Multi-hot select mid-frame, later digits must be ignored
        step(glyph_tab[5], 4'b0001, 1'b1, 1'b1, 1'b0);
        step(glyph_tab[6], 4'b0010, 1'b1, 1'b1, 1'b0);
        step(glyph_tab[7], 4'b0110, 1'b1, 1'b1, 1'b0);
        chk("multihot_selerr", 32'(se_h), 32'h1);
        step(glyph_tab[7], 4'b0100, 1'b1, 1'b1, 1'b0);
        chk("multihot_selerr_pulse", 32'(se_h), 32'h0);
        step(glyph_tab[8], 4'b1000, 1'b1, 1'b1, 1'b0);
        chk("multihot_idle", 32'(fv_h), 32'h0);

        // Overrun: two frames with no handshake, then clear, then handshake
        scan(glyphs_of(16'h1234), 1'b0, 1'b0);
        chk("ovr_first_bcd", 32'(bcd_h), 32'h1234);
        scan(glyphs_of(16'h5678), 1'b0, 1'b0);
        chk("ovr_bcd", 32'(bcd_h), 32'h5678);
        chk("ovr_set", 32'(ov_h), 32'h1);
        idle(1'b0, 1'b1);
        chk("ovr_clr", 32'(ov_h), 32'h0);
        chk("ovr_vld_hold", 32'(fv_h), 32'h1);
        idle(1'b1, 1'b0);
        chk("ovr_vld_drop", 32'(fv_h), 32'h0);

        // Completion coincident with a handshake
        scan(glyphs_of(16'h1111), 1'b0, 1'b0);
        scan(glyphs_of(16'h2468), 1'b0, 1'b1);
        chk("coinc_vld", 32'(fv_h), 32'h1);
        chk("coinc_bcd", 32'(bcd_h), 32'h2468);
        chk("coinc_ovr", 32'(ov_h), 32'h0);

        // Reset at digit 2 with a frame pending
        frame_a = glyphs_of(16'h9999);
        for (int k = 0; k < 3; k++) step(frame_a[7*k +: 7], 4'(1 << k), 1'b1, 1'b0, 1'b0);
        mid_reset();
        step(frame_a[27:21], 4'b1000, 1'b1, 1'b1, 1'b0);
        chk("post_rst_noframe", 32'(fv_h), 32'h0);

        // Randomised traffic against the model
        pos = 0;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 19);
            v = ($urandom_range(0, 3) != 0);
            if (r < 12)      s = 4'(1 << pos);
            else if (r < 16) s = 4'(1 << $urandom_range(0, 3));
            else if (r < 18) s = 4'h0;
            else             s = 4'($urandom);
            r = $urandom_range(0, 9);
            if (r < 8)       g = glyph_tab[$urandom_range(0, 9)];
            else if (r == 8) g = 7'h00;
            else             g = 7'($urandom);
            step(g, s, v, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            if (v) pos = (pos == N - 1) ? 0 : pos + 1;
            if (c % 700 == 350) mid_reset();
        end

        frame_b = glyphs_of(16'h0420);
        scan(frame_b, 1'b1, 1'b1);
        chk("final_bcd", 32'(bcd_h), 32'h0420);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
